// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - borrow_in over WIDTH bits, BITS_PER_CYCLE bits per clock,
// with a registered borrow between slices and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_next;
  logic                      accept, last_step;
  logic [WIDTH-1:0]          a_sh, b_sh, res_sh, res_next;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic                      brw, brw_next, b_chain;
  logic                      a_msb, b_msb;
  logic [CNT_W-1:0]          cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        last_step = (cnt == LAST);
        if (last_step) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor chain across one slice; the result slice enters the result register from the top.
  always_comb begin
    slice   = '0;
    b_chain = brw;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice[i] = a_sh[i] ^ b_sh[i] ^ b_chain;
      b_chain  = (~a_sh[i] & (b_sh[i] | b_chain)) | (b_sh[i] & b_chain);
    end
    brw_next = b_chain;
    res_next = (res_sh >> BITS_PER_CYCLE) | (WIDTH'(slice) << (WIDTH - BITS_PER_CYCLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      brw      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        brw   <= borrow_in;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> BITS_PER_CYCLE;
        b_sh   <= b_sh >> BITS_PER_CYCLE;
        res_sh <= res_next;
        brw    <= brw_next;
        cnt    <= cnt + 1'b1;
        // Results only move on completion, so they hold steady while the next operation runs.
        if (last_step) begin
          diff     <= res_next;
          borrow   <= brw_next;
          overflow <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
          zero     <= (res_next == '0);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit/1-bit-per-cycle and 16-bit/4-bits-per-cycle instances,
// expected results queued at issue time and checked when done pulses.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] d;
    logic        br;
    logic        ov;
    logic        z;
    int          due;
  } exp_t;

  logic        clk, rst_n;
  logic        start8, bin8, busy8, done8, borrow8, ovf8, zero8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, bin16, busy16, done16, borrow16, ovf16, zero16;
  logic [15:0] a16, b16, diff16;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q16[$];

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .borrow_in(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .overflow(ovf16), .zero(zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives an 8-bit request (start held) and queues its reference result.
  task automatic push8(input logic [7:0] av, input logic [7:0] bv, input logic bin);
    exp_t e;
    int full, sd;
    full = int'(av) - int'(bv) - int'(bin);
    sd   = int'($signed(av)) - int'($signed(bv)) - int'(bin);
    e.d   = {8'h00, full[7:0]};
    e.br  = (full < 0);
    e.ov  = (sd > 127) || (sd < -128);
    e.z   = (full[7:0] == 8'h00);
    e.due = cyc + 1 + 8;
    q8.push_back(e);
    a8 = av; b8 = bv; bin8 = bin; start8 = 1'b1;
  endtask

  task automatic push16(input logic [15:0] av, input logic [15:0] bv, input logic bin);
    exp_t e;
    int full, sd;
    full = int'(av) - int'(bv) - int'(bin);
    sd   = int'($signed(av)) - int'($signed(bv)) - int'(bin);
    e.d   = full[15:0];
    e.br  = (full < 0);
    e.ov  = (sd > 32767) || (sd < -32768);
    e.z   = (full[15:0] == 16'h0000);
    e.due = cyc + 1 + 4;
    q16.push_back(e);
    a16 = av; b16 = bv; bin16 = bin; start16 = 1'b1;
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) return;
    end
    check("timeout_done8", 32'd0, 32'd1);
    q8.delete();
  endtask

  task automatic wait_done16();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done16) return;
    end
    check("timeout_done16", 32'd0, 32'd1);
    q16.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("latency8", cyc, e.due);
        check("diff8", {24'd0, diff8}, {16'd0, e.d});
        check("borrow8", {31'd0, borrow8}, {31'd0, e.br});
        check("overflow8", {31'd0, ovf8}, {31'd0, e.ov});
        check("zero8", {31'd0, zero8}, {31'd0, e.z});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) check("unexpected_done16", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        check("latency16", cyc, e.due);
        check("diff16", {16'd0, diff16}, {16'd0, e.d});
        check("borrow16", {31'd0, borrow16}, {31'd0, e.br});
        check("overflow16", {31'd0, ovf16}, {31'd0, e.ov});
        check("zero16", {31'd0, zero16}, {31'd0, e.z});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset8", {19'd0, busy8, done8, diff8, borrow8, ovf8, zero8}, 32'd0);
    check("reset16", {11'd0, busy16, done16, diff16, borrow16, ovf16, zero16}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 5-3 with busy window of exactly 8 cycles.
    push8(8'h05, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      check("busy_run8", {31'd0, busy8}, 32'd1);
    end
    @(negedge clk);
    check("busy_end8", {31'd0, busy8}, 32'd0);
    check("done_end8", {31'd0, done8}, 32'd1);
    @(negedge clk);
    check("done_pulse8", {31'd0, done8}, 32'd0);

    // Borrow, borrow_in, signed overflow and zero corners.
    push8(8'h03, 8'h05, 1'b0); @(negedge clk); start8 = 1'b0; wait_done8();
    push8(8'h00, 8'h00, 1'b1); @(negedge clk); start8 = 1'b0; wait_done8();
    push8(8'h80, 8'h01, 1'b0); @(negedge clk); start8 = 1'b0; wait_done8();
    push8(8'h7F, 8'hFF, 1'b0); @(negedge clk); start8 = 1'b0; wait_done8();
    push8(8'h5A, 8'h5A, 1'b0); @(negedge clk); start8 = 1'b0; wait_done8();

    // start held and operands scrambled while running: only the first operands count.
    @(negedge clk);
    push8(8'h37, 8'h12, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'b1;
      check("results_hold8", {24'd0, diff8}, 32'h0000_0000);
    end
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();

    // Back-to-back: new start in the done cycle.
    @(negedge clk);
    push8(8'h20, 8'h08, 1'b1); @(negedge clk); start8 = 1'b0;
    wait_done8();
    push8(8'h44, 8'h45, 1'b0); @(negedge clk); start8 = 1'b0;
    wait_done8();

    // Reset three cycles into an operation: abandoned, outputs cleared, no done.
    @(negedge clk);
    push8(8'hC3, 8'h11, 1'b0); @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset8", {19'd0, busy8, done8, diff8, borrow8, ovf8, zero8}, 32'd0);
    q8.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_reset_no_done8", {31'd0, done8}, 32'd0);
      if (i == 1) rst_n = 1'b1;
    end
    push8(8'h10, 8'h01, 1'b0); @(negedge clk); start8 = 1'b0; wait_done8();

    // Random back-to-back on the 8-bit instance.
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      push8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk); start8 = 1'b0;
      wait_done8();
    end

    // Wide instance: directed case then 1000 random back-to-back operations.
    @(negedge clk);
    push16(16'h1234, 16'h4321, 1'b0); @(negedge clk); start16 = 1'b0; wait_done16();
    push16(16'h8000, 16'h0001, 1'b0); @(negedge clk); start16 = 1'b0; wait_done16();
    push16(16'h0000, 16'h0000, 1'b1); @(negedge clk); start16 = 1'b0; wait_done16();
    for (int i = 0; i < 1000; i++) begin
      push16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk); start16 = 1'b0;
      wait_done16();
    end

    repeat (12) @(negedge clk);
    check("drained8", q8.size(), 32'd0);
    check("drained16", q16.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor computing A - B - borrow_in over WIDTH bits. Processes BITS_PER_CYCLE bits per clock, with a registered borrow chained between slices. Provides a start/busy/done handshake, borrow-out, signed overflow and zero flags. Intended as the area-cheap arithmetic unit for the lab's datapath exercises, where a full-width combinational subtractor is not wanted.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active low
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
borrow_in  input  1  initial borrow; sampled on the accepting edge only
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results update
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow  output  1  unsigned borrow out of the MSB (1 when a < b + borrow_in)
overflow  output  1  signed two's-complement overflow of a - b - borrow_in
zero  output  1  diff == 0

Behaviour:
- Reset is asynchronous and active low: one clock, clk; reset rst_n. While rst_n=0: state=IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0, internal shift registers and step counter cleared.
- STEPS = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: busy=0. Edge with start=1: latch a, b and borrow_in into the internal shift registers and borrow flop. Also latch a[MSB] and b[MSB] for the overflow calculation. Clear the counter and go to RUN.
  - RUN: busy=1. Each edge subtracts the low BITS_PER_CYCLE bits of the shift registers with the borrow flop (full-subtractor slice chain). It shifts the result slice into the result register from the top, updates the borrow flop and increments the counter. On the edge that completes step STEPS:
    - Load diff, borrow, overflow and zero.
    - Pulse done=1 for exactly that one cycle.
    - Drop busy to 0 and return to IDLE.
- Latency: start accepted at edge k gives busy=1 for cycles k..k+STEPS-1, and done=1 with valid results in the cycle following edge k+STEPS. That is STEPS cycles.
- Result outputs hold their last value until the next completion. They do not change while a new operation is running.
- Back-to-back: start=1 during the done cycle is accepted, because busy=0 then. There are no dead cycles.
- start while busy=1: ignored. Operands and borrow_in are not resampled.
- overflow = (a_msb != b_msb) && (diff[MSB] != a_msb), using the latched MSBs. borrow_in is included in the arithmetic.
- zero is computed on the final diff value.
- Reset asserted mid-operation: the operation is abandoned immediately, no done pulse occurs, and all outputs go to reset values.
- a, b and borrow_in are don't-care except on the accepting edge.

Test Plan:
1. WIDTH=8, BPC=1, a=0x05, b=0x03, bin=0, pulse start → busy high for 8 cycles, then done=1 for 1 cycle with diff=0x02, borrow=0, overflow=0, zero=0.
2. a=0x03, b=0x05, bin=0 → diff=0xFE, borrow=1, overflow=0. Also a=0x00, b=0x00, bin=1 → diff=0xFF, borrow=1, zero=0.
3. Signed overflow and zero:
   - a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1.
   - a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
   - a=0x5A, b=0x5A → diff=0x00, zero=1.
4. Handshake:
   - start held high and operands changed during RUN → the result reflects only the first operands.
   - start=1 in the done cycle → a second done exactly 8 cycles later, with no gap.
5. Mid-operation reset: deassert rst_n 3 cycles after start → all outputs 0 immediately and no done. After release, a new operation 0x10-0x01 gives diff=0x0F.
6. WIDTH=16, BPC=4, a=0x1234, b=0x4321 → done 4 cycles after start with diff=0xCF13, borrow=1, overflow=0. Randomised 1000 operations compared against a reference model of a-b-bin.
